lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
Load/store initiator that sits between the execute stage and the word-addressed data memory. It takes one RISC-V load or store request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW, selected by funct3. It converts the byte address to a word index and drives the memory's write-enable, address and write-data. It returns sign- or zero-extended load data and performs read-modify-write for SB/SH, because the memory only writes whole words.

Parameters:
MEM_WORDS, 4000, number of 32-bit words in the attached memory; word indices at or above this value are out of range.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE; a request is accepted on a posedge where req_valid && req_ready.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I width/sign code.
req_addr  input  32  byte address.
req_wdata  input  32  store data; SB uses [7:0], SH uses [15:0].
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  valid with resp_valid; request rejected.
mem_we  output  1  memory write enable.
mem_addr  output  32  word index, equal to req_addr[31:2].
mem_wdata  output  32  memory write data.
mem_rdata  input  32  memory read data; combinational from mem_addr.

Behaviour:
- States: IDLE, RD, WR, RESP. Request fields are registered on accept.
- Error check, done at accept:
  - LH/LHU/SH with addr[0]=1 is an error.
  - LW/SW with addr[1:0]!=0 is an error.
  - Word index >= MEM_WORDS is an error.
  - Load funct3 in {3,6,7} is an error.
  - Store funct3 > 2 is an error.
  - Error path: IDLE->RESP with resp_err=1 and resp_rdata=0. No memory access and no mem_we.
- Load path: IDLE->RD->RESP.
  - mem_addr holds the index during RD.
  - At the RD->RESP edge, the byte/half selected by addr[1:0] is extracted from mem_rdata and extended: LB/LH sign-extend, LBU/LHU zero-extend. The result is registered into resp_rdata.
- SW path: IDLE->WR->RESP. In WR, mem_we=1 and mem_wdata=req_wdata. The write commits at the WR->RESP edge.
- SB/SH path: IDLE->RD->WR->RESP.
  - At the RD->WR edge, the mem_rdata word is captured and the target byte/half is replaced. Byte lane = addr[1:0]; half lane = addr[1].
  - In WR, mem_wdata carries the merged word.
- Latency from the accept edge to resp_valid: errors 1 cycle; loads and SW 2 cycles; SB/SH 3 cycles.
- RESP lasts exactly one cycle, then returns to IDLE; req_ready is high again on the next cycle.
- Back-to-back requests are allowed.
- There is no response backpressure; the requester must take the pulse.
- req_valid while not IDLE is ignored, and no request fields are sampled.
- mem_we is high only in WR, exactly one cycle per store.
- mem_addr = registered index in RD/WR, otherwise 0.
- mem_wdata = 0 outside WR.
- Reset (async) values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts immediately. A store interrupted before its WR->RESP edge never commits, and no response is issued.

Test Plan:
Bench memory model: word-indexed, combinational read, posedge write, MEM_WORDS=4000.
1. Reset pulse with req_valid=1 -> all outputs at reset values and req_ready=1; no accept while rst=0.
2. SW addr 0x10 data 0xDEADBEEF -> mem_we high exactly 1 cycle with mem_addr=4 and mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept with err=0. Then LW 0x10 -> resp_rdata=0xDEADBEEF 2 cycles after accept.
3. With word 4 = 0xDEADBEEF, loads return:
   - LB 0x13 -> 0xFFFFFFDE
   - LBU 0x13 -> 0x000000DE
   - LH 0x12 -> 0xFFFFDEAD
   - LHU 0x10 -> 0x0000BEEF
   - LB 0x10 -> 0xFFFFFFEF
4. SB 0x11 data 0x12345677 -> word 4 becomes 0xDEAD77EF and resp at +3 cycles. Then SH 0x12 data 0x0000CAFE -> word 4 = 0xCAFE77EF.
5. Each of these -> resp_err=1, resp_rdata=0 one cycle after accept, mem_we never asserted:
   - LW 0x11
   - SH 0x13
   - LW at byte address 4*4000
   - load funct3=3
6. Issue SB 0x20 and assert rst during RD -> mem_we stays 0, word 8 unchanged, no resp_valid. After release, back-to-back LW/SW requests complete with correct latencies.

Source files
------------

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator for a word-addressed data memory.
// Handles one request at a time; sub-word stores use read-modify-write.
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nx;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        req_err;

  assign accept = req_valid && req_ready;

  // Extract the addressed byte/half from a memory word and sign/zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Replace the target byte (SB) or half (SH) lane of the current word.
  function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word,
                                              input logic [31:0] data);
    logic [31:0] merged;
    merged = word;
    if (f3[0]) merged[{off[1], 4'b0000} +: 16] = data[15:0];
    else       merged[{off, 3'b000} +: 8]      = data[7:0];
    return merged;
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      if (req_funct3 > 3'd2) req_err = 1'b1;
    end else if (req_funct3 == 3'd3 || req_funct3 >= 3'd6) begin
      req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS)              req_err = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                           state_nx = RESP;
          else if (req_we && req_funct3 == 3'd2) state_nx = WR;
          else                                   state_nx = RD;
        end
      end
      RD:      state_nx = we_q ? WR : RESP;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            rdata_q  <= 32'h0;
          end
        end
        RD: begin
          // Stores reuse wdata_q to hold the merged word written in WR.
          if (we_q) wdata_q <= store_merge(funct3_q, addr_q[1:0], mem_rdata, wdata_q);
          else      rdata_q <= load_extend(funct3_q, addr_q[1:0], mem_rdata);
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = (state == RESP) ? rdata_q : 32'h0;
  assign mem_we     = (state == WR);
  assign mem_addr   = (state == RD || state == WR) ? {2'b00, addr_q[31:2]} : 32'h0;
  assign mem_wdata  = (state == WR) ? wdata_q : 32'h0;

endmodule
